// File: rtl/divreq_ctrl.sv
// divreq_ctrl: initiator side of the execute-stage RV32M divide handshake.
//
// Decodes DIV/DIVU/REM/REMU from the execute stage. It launches each op on the
// divide unit with a one-cycle start pulse and stalls the pipeline while the op
// is in flight. It captures the quotient or remainder and presents a one-cycle
// writeback. The divide unit handles all signed, divide-by-zero and overflow
// fix-ups.
//
// Optional build macro: DIVREM_REUSE_EN
//   When defined, the last completed operand pair and its results are cached.
//   A matching request (e.g. REM after DIV on the same operands) completes
//   from the cache without starting the divider.
//
// Ports
//   clk, cpurst                      core clock, async active-high reset
//   ex_valid/ex_isdiv/ex_funct3      execute-stage decode
//   ex_rs1/ex_rs2/ex_rd              operands and destination
//   ex_flush                         kill in-flight op
//   dividend/divider/divsigned       registered operands to the divide unit
//   diven_p                          registered start pulse
//   diven/divout_valid/quo/rem       divide unit status and results
//   ex_stall                         hold execute stage
//   wb_valid/wb_rd/wb_data           one-cycle writeback
//   div_err                          one-cycle timeout pulse
module divreq_ctrl #(
    parameter int DIV_TIMEOUT = 63,
    parameter int RDW         = 5
) (
    input  logic           clk,
    input  logic           cpurst,
    input  logic           ex_valid,
    input  logic           ex_isdiv,
    input  logic [2:0]     ex_funct3,
    input  logic [31:0]    ex_rs1,
    input  logic [31:0]    ex_rs2,
    input  logic [RDW-1:0] ex_rd,
    input  logic           ex_flush,
    output logic [31:0]    dividend,
    output logic [31:0]    divider,
    output logic           divsigned,
    output logic           diven_p,
    input  logic           diven,
    input  logic           divout_valid,
    input  logic [31:0]    quo,
    input  logic [31:0]    rem,
    output logic           ex_stall,
    output logic           wb_valid,
    output logic [RDW-1:0] wb_rd,
    output logic [31:0]    wb_data,
    output logic           div_err
);

    localparam int CW = $clog2(DIV_TIMEOUT + 1);
    // The counter starts at 0 in the first WAIT cycle, which is one cycle after
    // diven_p. Firing at DIV_TIMEOUT-2 puts the registered div_err pulse
    // exactly DIV_TIMEOUT cycles after diven_p.
    localparam logic [CW-1:0] TO_LAST = CW'(DIV_TIMEOUT - 2);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          selrem;
    logic          req;
    logic          timeout;
    logic          hit;
    logic [31:0]   hit_data;
    logic          unused_funct3;

    // funct3[2] is always 1 for the M-extension divides.
    assign unused_funct3 = ex_funct3[2];

    assign req     = ex_valid & ex_isdiv & ~ex_flush;
    assign timeout = (state == WAIT) & ~divout_valid & (cnt == TO_LAST);

`ifdef DIVREM_REUSE_EN
    logic        c_vld;
    logic        c_s;
    logic [31:0] c_a, c_b, c_q, c_r;

    assign hit      = c_vld & (c_a == ex_rs1) & (c_b == ex_rs2) & (c_s == ~ex_funct3[0]);
    assign hit_data = ex_funct3[1] ? c_r : c_q;

    // A discarded or abandoned op must never seed the cache.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            c_vld <= 1'b0;
            c_s   <= 1'b0;
            c_a   <= '0;
            c_b   <= '0;
            c_q   <= '0;
            c_r   <= '0;
        end else if (ex_flush || state == DRAIN || timeout) begin
            c_vld <= 1'b0;
        end else if (state == WAIT && divout_valid) begin
            c_vld <= 1'b1;
            c_s   <= divsigned;
            c_a   <= dividend;
            c_b   <= divider;
            c_q   <= quo;
            c_r   <= rem;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            state     <= IDLE;
            cnt       <= '0;
            dividend  <= '0;
            divider   <= '0;
            divsigned <= 1'b0;
            selrem    <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            diven_p   <= 1'b0;
            div_err   <= 1'b0;
        end else begin
            diven_p <= 1'b0;
            div_err <= 1'b0;
            case (state)
                IDLE: begin
                    // A cache hit does not need the divider, so it is not
                    // blocked by diven.
                    if (req && (hit || !diven)) begin
                        dividend  <= ex_rs1;
                        divider   <= ex_rs2;
                        divsigned <= ~ex_funct3[0];
                        selrem    <= ex_funct3[1];
                        wb_rd     <= ex_rd;
                        if (hit) begin
                            wb_data <= hit_data;
                            state   <= DONE;
                        end else begin
                            diven_p <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // The start pulse is already on the wire. The divider
                    // cannot abort, so a flush here still has to drain.
                    cnt   <= '0;
                    state <= ex_flush ? DRAIN : WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (ex_flush) begin
                        // A result arriving with the flush is simply dropped.
                        state <= divout_valid ? IDLE : DRAIN;
                    end else if (divout_valid) begin
                        wb_data <= selrem ? rem : quo;
                        state   <= DONE;
                    end else if (timeout) begin
                        div_err <= 1'b1;
                        state   <= IDLE;
                    end
                end
                DONE:  state <= IDLE;
                DRAIN: if (divout_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Both outputs are gated by reset so that every output reads 0 while
    // cpurst is high.
    assign ex_stall = ~cpurst & (((state == IDLE) & req) | (state == ISSUE) |
                                 (state == WAIT) | ((state == DRAIN) & req));
    assign wb_valid = ~cpurst & (state == DONE) & ~ex_flush;

endmodule
